mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADR_MSB, default 15: MSB of the bus address.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12: log2 of the byte capacity of the local array.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15: inserted wait cycles per access.
REQ-004 SHALL have parameter ROM_TOP, default 16'h0100: first writable address when write protect is compiled in.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port m_cs, input, 1 bit: access request from the core.
REQ-008 SHALL have port m_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port m_addr, input, ADR_MSB+1 bits: byte address.
REQ-010 SHALL have port m_odata, input, 8 bits: write data from the core.
REQ-011 SHALL have port m_idata, output, 8 bits: read data to the core.
REQ-012 SHALL have port m_wait, output, 1 bit: 1 = access not complete; 0 = data valid / write committed.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, ACK.
REQ-014 IDLE: m_cs=1 sampled at edge t0 SHALL capture m_addr, m_we and m_odata, load the wait counter with WAIT_CYCLES, and enter BUSY.
REQ-015 BUSY: the counter SHALL decrement each edge; at 0 the FSM SHALL enter ACK, so ACK spans the cycle after edge t0+1+WAIT_CYCLES.
REQ-016 m_wait SHALL be 0 only while in ACK; it SHALL be 1 in IDLE and BUSY.
REQ-017 A read SHALL register array[captured addr] into m_idata on the edge entering ACK; m_idata SHALL hold that value until the next read completes.
REQ-018 A write SHALL commit captured m_odata to the array on the edge entering ACK, exactly once per access.
REQ-019 ACK SHALL return to IDLE after one cycle; m_cs still high in the following IDLE cycle SHALL count as a new request (back-to-back low/high byte accesses).
REQ-020 m_cs=0 sampled in BUSY SHALL abort the access: return to IDLE, no write, m_idata unchanged.
REQ-021 Changes on m_addr, m_we or m_odata after capture SHALL be ignored until the next IDLE capture.
REQ-022 Array index SHALL be m_addr[DEPTH_LOG2-1:0]; higher address bits SHALL be ignored, so addresses mirror with period 2^DEPTH_LOG2.
REQ-023 With WAIT_CYCLES=0, BUSY SHALL last exactly one cycle.

Reset
REQ-024 rst SHALL asynchronously force IDLE, counter=0, m_wait=1 and m_idata=8'h00.
REQ-025 rst asserted mid-access SHALL abort it with no write.
REQ-026 Array contents SHALL NOT be cleared by rst.

Configuration
REQ-027 With MEM_RESP_WRITE_PROTECT_EN defined, writes to captured addresses below ROM_TOP SHALL be acknowledged with normal timing and SHALL NOT modify the array.
REQ-028 Without MEM_RESP_WRITE_PROTECT_EN, all addresses SHALL be writable and ROM_TOP SHALL have no effect.

Structure
REQ-029 FSM state encodings and the wait-counter width (4 bits) SHALL live in shared package dust16_bus_pkg.
REQ-030 The byte array SHALL be a sub-module mem_resp_ram: single-port, synchronous read, one write enable, depth 2^DEPTH_LOG2 x 8.

Verification
REQ-031 Bench SHALL cover, with WAIT_CYCLES=2: write 8'hA5 to 16'h0200, then read 16'h0200 -> m_wait low in exactly the 4th cycle after each m_cs sample, and the read returns 8'hA5.
REQ-032 Bench SHALL cover: m_cs held high across two accesses to 16'h0300 and 16'h0301 -> two separate ACK pulses, with correct bytes in order.
REQ-033 Bench SHALL cover: m_cs dropped during BUSY of a write of 8'h3C to 16'h0400 -> a later read of 16'h0400 returns the prior value.
REQ-034 Bench SHALL cover, with DEPTH_LOG2=12: write 8'h77 to 16'h1005, then read 16'h0005 -> returns 8'h77 (mirror).
REQ-035 Bench SHALL cover, with MEM_RESP_WRITE_PROTECT_EN defined: write 8'hFF to 16'h0010 -> ACK still occurs and a readback is unchanged; without the macro the readback is 8'hFF.
REQ-036 Bench SHALL cover: rst pulsed during BUSY -> m_wait=1 and m_idata=8'h00 immediately, and no write occurs.

Source files
------------

// File: rtl/dust16_bus_pkg.sv
// Shared definitions for the dust16 bus responder family:
// FSM state encoding, wait-counter width and a counter-load helper.
package dust16_bus_pkg;

  // Wait counter is 4 bits wide, so WAIT_CYCLES is limited to 0..15.
  localparam int unsigned WAIT_CNT_W = 4;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_ACK  = 2'b10
  } resp_state_t;

  // Truncates the configured wait-cycle count to the counter width.
  function automatic wait_cnt_t wait_load(input int unsigned cycles);
    return wait_cnt_t'(cycles);
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port byte RAM for mem_responder: 2^DEPTH_LOG2 x 8,
// synchronous read, one write enable. The read-data register is reset
// to zero; the storage array itself is never cleared.
module mem_resp_ram #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0] mem [DEPTH];

  // Storage write: commits one byte when enabled for a write.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: updates only on an enabled read, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: captures a byte access from the core in
// IDLE, holds m_wait high for 1+WAIT_CYCLES BUSY cycles, then completes
// the access on the edge entering a one-cycle ACK. Dropping m_cs during
// BUSY (or asserting rst) abandons the access with no write.
// Optional feature macro: MEM_RESP_WRITE_PROTECT_EN -- when defined,
// writes to captured addresses below ROM_TOP are acknowledged but dropped.
module mem_responder
  import dust16_bus_pkg::*;
#(
  parameter int unsigned ADR_MSB     = 15,
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ROM_TOP     = 16'h0100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m_cs,
  input  logic           m_we,
  input  logic [ADR_MSB:0] m_addr,
  input  logic [7:0]     m_odata,
  output logic [7:0]     m_idata,
  output logic           m_wait
);

  typedef logic [ADR_MSB:0] addr_t;

  localparam addr_t ROM_TOP_A = addr_t'(ROM_TOP);

  resp_state_t state_q, state_d;
  wait_cnt_t   cnt_q, cnt_d;
  addr_t       cap_addr;
  logic        cap_we;
  logic [7:0]  cap_data;
  logic        capture;
  logic        complete;
  logic        wr_block;
  logic        ram_en;

`ifdef MEM_RESP_WRITE_PROTECT_EN
  // Protection compares the full captured address, so mirrors of a
  // protected index above ROM_TOP remain writable.
  assign wr_block = (cap_addr < ROM_TOP_A);
`else
  logic unused_cfg;
  assign wr_block   = 1'b0;
  assign unused_cfg = ^{ROM_TOP_A, cap_addr[ADR_MSB:DEPTH_LOG2]};
`endif

  // A blocked write must not enable the RAM at all; enabling it with
  // we low would turn the access into a read and disturb m_idata.
  assign ram_en = complete && (!cap_we || !wr_block);

  assign m_wait = (state_q != ST_ACK);

  // State and wait-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture: address, direction and data latched in IDLE only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr <= '0;
      cap_we   <= 1'b0;
      cap_data <= '0;
    end else if (capture) begin
      cap_addr <= m_addr;
      cap_we   <= m_we;
      cap_data <= m_odata;
    end
  end

  // Next-state logic: IDLE captures, BUSY counts down or aborts, ACK
  // lasts exactly one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m_cs) begin
          state_d = ST_BUSY;
          cnt_d   = wait_load(WAIT_CYCLES);
          capture = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!m_cs) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = ST_ACK;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  mem_resp_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (cap_we),
    .addr  (cap_addr[DEPTH_LOG2-1:0]),
    .wdata (cap_data),
    .rdata (m_idata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder with a byte-array
// reference model. Honors MEM_RESP_WRITE_PROTECT_EN when defined.
module tb_mem_responder;

  localparam int unsigned W   = 2;
  localparam int unsigned DL  = 12;
  localparam int unsigned ROM = 16'h0100;
`ifdef MEM_RESP_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cs;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_odata;
  logic [7:0]  m_idata;
  logic        m_wait;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_model [1 << DL];
  logic [7:0]  idata_model;
  logic [11:0] pool [16] = '{12'h005, 12'h010, 12'h0FF, 12'h100,
                             12'h200, 12'h201, 12'h2FE, 12'h300,
                             12'h301, 12'h302, 12'h400, 12'h401,
                             12'h7FF, 12'h800, 12'hA55, 12'hFFF};

  always #5 clk = ~clk;

  mem_responder #(
    .ADR_MSB     (15),
    .DEPTH_LOG2  (DL),
    .WAIT_CYCLES (W),
    .ROM_TOP     (ROM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cs    (m_cs),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_odata (m_odata),
    .m_idata (m_idata),
    .m_wait  (m_wait)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit writable(input logic [15:0] a);
    return !(WP && (a < 16'(ROM)));
  endfunction

  // Presents a request at an IDLE-cycle negedge, then scrambles the
  // request fields after the capturing edge.
  task automatic start(input bit we, input logic [15:0] a, input logic [7:0] d);
    m_cs    = 1'b1;
    m_we    = we;
    m_addr  = a;
    m_odata = d;
    @(posedge clk);
    #1;
    m_we    = 1'($urandom);
    m_addr  = 16'($urandom);
    m_odata = 8'($urandom);
  endtask

  task automatic access(input bit we, input logic [15:0] a, input logic [7:0] d, input bit keep_cs);
    logic [11:0] ix;
    ix = a[11:0];
    start(we, a, d);
    for (int k = 1; k <= int'(W) + 2; k++) begin
      @(negedge clk);
      check($sformatf("wait_cyc%0d", k), 32'(m_wait), (k == int'(W) + 2) ? 32'd0 : 32'd1);
    end
    if (!we) idata_model = mem_model[ix];
    else if (writable(a)) mem_model[ix] = d;
    check($sformatf("ack_idata_%0h", a), 32'(m_idata), 32'(idata_model));
    m_cs = keep_cs;
    @(negedge clk);
    check("wait_after_ack", 32'(m_wait), 32'd1);
    check("idata_hold", 32'(m_idata), 32'(idata_model));
  endtask

  task automatic abort_access(input bit we, input logic [15:0] a, input logic [7:0] d);
    int unsigned k;
    k = $urandom_range(1, W + 1);
    start(we, a, d);
    for (int unsigned j = 1; j <= k; j++) begin
      @(negedge clk);
      check("abort_busy_wait", 32'(m_wait), 32'd1);
    end
    m_cs = 1'b0;
    @(negedge clk);
    check("abort_wait", 32'(m_wait), 32'd1);
    check("abort_idata", 32'(m_idata), 32'(idata_model));
  endtask

  task automatic reset_mid(input bit we, input logic [15:0] a, input logic [7:0] d);
    int unsigned k;
    k = $urandom_range(1, W + 1);
    start(we, a, d);
    for (int unsigned j = 1; j <= k; j++) begin
      @(negedge clk);
      check("rst_busy_wait", 32'(m_wait), 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    idata_model = 8'h00;
    check("rst_wait", 32'(m_wait), 32'd1);
    check("rst_idata", 32'(m_idata), 32'(idata_model));
    m_cs = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_idle_wait", 32'(m_wait), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  prior;
    logic [15:0] a;
    logic [31:0] r;
    rst = 1'b1; m_cs = 1'b0; m_we = 1'b0; m_addr = '0; m_odata = '0;
    idata_model = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_wait", 32'(m_wait), 32'd1);
    check("reset_idata", 32'(m_idata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Initialise every pool location through a writable mirror.
    for (int i = 0; i < 16; i++) access(1'b1, {4'h1, pool[i]}, 8'($urandom), 1'b0);

    access(1'b1, 16'h0200, 8'hA5, 1'b0);
    access(1'b0, 16'h0200, 8'h00, 1'b0);
    check("read_a5", 32'(m_idata), 32'hA5);

    access(1'b1, 16'h0300, 8'h12, 1'b1);
    access(1'b1, 16'h0301, 8'h34, 1'b1);
    access(1'b0, 16'h0300, 8'h00, 1'b1);
    check("b2b_lo", 32'(m_idata), 32'h12);
    access(1'b0, 16'h0301, 8'h00, 1'b0);
    check("b2b_hi", 32'(m_idata), 32'h34);

    prior = mem_model[12'h400];
    abort_access(1'b1, 16'h0400, 8'h3C);
    access(1'b0, 16'h0400, 8'h00, 1'b0);
    check("abort_no_write", 32'(m_idata), 32'(prior));

    access(1'b1, 16'h1005, 8'h77, 1'b0);
    access(1'b0, 16'h0005, 8'h00, 1'b0);
    check("mirror", 32'(m_idata), 32'h77);

    prior = mem_model[12'h010];
    access(1'b1, 16'h0010, 8'hFF, 1'b0);
    access(1'b0, 16'h0010, 8'h00, 1'b0);
    check("protect", 32'(m_idata), WP ? 32'(prior) : 32'hFF);

    prior = mem_model[12'h200];
    reset_mid(1'b1, 16'h0200, 8'h5A);
    access(1'b0, 16'h0200, 8'h00, 1'b0);
    check("rst_no_write", 32'(m_idata), 32'(prior));

    for (int n = 0; n < 80; n++) begin
      r = $urandom;
      a = {r[3:0], pool[r[7:4]]};
      case (r[11:8] % 10)
        0, 1, 2, 3: access(1'b1, a, r[23:16], r[24]);
        4, 5, 6:    access(1'b0, a, r[23:16], r[24]);
        7:          abort_access(r[25], a, r[23:16]);
        8:          reset_mid(r[25], a, r[23:16]);
        default: begin
          access(r[25], a, r[23:16], 1'b1);
          access(r[26], a ^ 16'h0001, r[31:24], r[24]);
        end
      endcase
    end
    m_cs = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
